layer1_weight_sequencer: RTL
============================

Name: layer1_weight_sequencer

Overview:
- Controller that owns the Layer 1 weight storage array of INPUT_LAYER_NODES banks, each bank RELU_NODES x LAYER_1_BIT_WIDTH.
- LOAD mode: accepts a serial weight stream, assembles one bank-width row, and performs a timed latch write (setup/pulse/hold) into each bank in turn.
- SCAN mode: walks the node select across all banks and presents each row to the Layer 1 accumulator under a valid/ready handshake.
- Shares the storage between the loader and the accumulator; only one mode is active at a time.

Parameters:
- INPUT_LAYER_NODES, 784, number of banks (input pixels).
- RELU_NODES, 16, weights per bank row.
- LAYER_1_BIT_WIDTH, 8, bits per weight.
- NODE_SEL_WIDTH, 10, node-select width; must satisfy 2^NODE_SEL_WIDTH >= INPUT_LAYER_NODES.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- loadStart  in  1  request to begin a full weight load.
- weightIn  in  LAYER_1_BIT_WIDTH  serial weight word.
- weightValid  in  1  weightIn is valid.
- weightReady  out  1  sequencer accepts weightIn this cycle.
- scanStart  in  1  request to begin a scan of all rows.
- scanReady  in  1  accumulator accepts the current row.
- storeWriteEnable  out  1  storage latch enable.
- storeNodeSelect  out  NODE_SEL_WIDTH  storage bank select (write and read).
- storeWriteIn  out  RELU_NODES*LAYER_1_BIT_WIDTH  assembled row to storage.
- rowValid  out  1  current storage readOut is a valid scan row.
- rowIndex  out  NODE_SEL_WIDTH  index of the presented row (equals storeNodeSelect).
- rowLast  out  1  presented row is index INPUT_LAYER_NODES-1.
- busy  out  1  state is not IDLE.
- loaded  out  1  storage holds a complete, valid weight set.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; all outputs 0; row register, beat counter and row counter 0; loaded=0. Reset overrides any operation in progress; a load aborted by reset leaves loaded=0.
- States: IDLE, FILL, WR_SETUP, WR_PULSE, WR_HOLD, SCAN.
- IDLE:
  - loadStart=1 -> FILL; clear loaded, row counter and beat counter.
  - else scanStart=1 with loaded=1 -> SCAN; row counter=0.
  - If both starts are asserted together, loadStart wins.
  - scanStart with loaded=0 is ignored.
  - Both starts are ignored in every state other than IDLE.
- FILL:
  - weightReady=1 only in this state.
  - Each beat with weightValid&&weightReady writes weightIn into slice [b*W +: W], where W=LAYER_1_BIT_WIDTH and b is the beat counter; then b increments.
  - Slice 0 holds ReLU node 0.
  - Gaps in weightValid stall the fill without limit.
  - On the beat with b=RELU_NODES-1 -> WR_SETUP; b returns to 0.
- Write sequence (3 cycles per row):
  - WR_SETUP: storeNodeSelect=row counter, storeWriteIn=assembled row, storeWriteEnable=0.
  - WR_PULSE: storeWriteEnable=1 for exactly one cycle.
  - WR_HOLD: storeWriteEnable=0; data and select unchanged.
  - storeWriteIn and storeNodeSelect must be stable from WR_SETUP through WR_HOLD, because the storage is level-sensitive.
  - Leaving WR_HOLD: if row counter=INPUT_LAYER_NODES-1 -> IDLE with loaded=1; else increment the row counter -> FILL.
  - storeWriteEnable must never be 1 outside WR_PULSE.
- SCAN:
  - rowValid=1; rowIndex=storeNodeSelect=row counter; rowLast=(row counter==INPUT_LAYER_NODES-1).
  - The row advances only on rowValid&&scanReady; scanReady=0 holds the row indefinitely.
  - The storage read is combinational, so a new row is presented one cycle after acceptance, giving a throughput of 1 row/cycle with scanReady tied high.
  - Acceptance of the last row -> IDLE; rowValid=0 in the following cycle.
- In IDLE: storeNodeSelect=0, storeWriteEnable=0, rowValid=0, rowLast=0, weightReady=0. storeWriteIn holds its last value.
- Counter width: the row counter compares against INPUT_LAYER_NODES-1 and never wraps past it. The beat counter is $clog2(RELU_NODES) bits.

Optional Feature:
- Macro: WEIGHT_CHECKSUM_EN.
- Defined:
  - Adds output weightChecksum [15:0]: the modulo-2^16 sum of every accepted weightIn, zero-extended and treated as unsigned.
  - The sum clears on loadStart acceptance and on reset, and is frozen once loaded=1.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package NNGlobals: INPUT_LAYER_NODES, RELU_NODES, LAYER_1_BIT_WIDTH, NODE_SEL_WIDTH and the state encoding enum (seq_state_t).
- One natural sub-module: weight_row_assembler (FILL shift/slice register plus beat counter; outputs rowComplete). All remaining logic stays in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random inputs -> every output reads 0, state IDLE, loaded=0.
- Full load: loadStart, then stream weight value (n mod 256) for n=0..12543 with weightValid always 1 -> exactly 784 storeWriteEnable pulses, each 1 cycle wide. Bank 0 row is 0x0F0E..0100; select/data stable from WR_SETUP through WR_HOLD. loaded=1 after the last WR_HOLD. Total 784*(16+3) cycles.
- Stalls: weightValid 50% random, and scanReady toggling 1,0,0,1 -> no beat lost or duplicated. rowIndex is held while scanReady=0. rowLast is seen only at 783, and exactly 784 row acceptances occur.
- Guarding: scanStart with loaded=0 -> stays IDLE. loadStart and scanStart asserted together -> FILL. scanStart mid-load is ignored.
- Reset mid-operation: rst_n=0 during row 400 of a load -> IDLE, loaded=0, and no write pulse on the reset edge.
- WEIGHT_CHECKSUM_EN defined: load all weights =0xFF -> weightChecksum = (12544*255) mod 65536 = 0xCF00.

Source files
------------

// File: rtl/layer1_weight_sequencer_pkg.sv
// Shared Layer 1 sizing constants and the sequencer state encoding.
// Compile this file before the rest of the rtl/ sources.
package NNGlobals;

  localparam int INPUT_LAYER_NODES = 784;
  localparam int RELU_NODES        = 16;
  localparam int LAYER_1_BIT_WIDTH = 8;
  localparam int NODE_SEL_WIDTH    = 10;

  localparam int ROW_WIDTH  = RELU_NODES * LAYER_1_BIT_WIDTH;
  localparam int BEAT_WIDTH = $clog2(RELU_NODES);

  localparam logic [NODE_SEL_WIDTH-1:0] LAST_ROW  = NODE_SEL_WIDTH'(INPUT_LAYER_NODES - 1);
  localparam logic [BEAT_WIDTH-1:0]     LAST_BEAT = BEAT_WIDTH'(RELU_NODES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_SCAN
  } seq_state_t;

endpackage

// File: rtl/layer1_weight_sequencer_weight_row_assembler.sv
// Collects RELU_NODES serial weights into one bank-width row; slice 0 holds
// ReLU node 0. rowComplete flags the beat that fills the last slice.
module weight_row_assembler
  import NNGlobals::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear_i,
  input  logic                         beat_en_i,
  input  logic [LAYER_1_BIT_WIDTH-1:0] weight_i,
  output logic [ROW_WIDTH-1:0]         row_o,
  output logic                         row_complete_o
);

  logic [BEAT_WIDTH-1:0] beat_q, beat_d;
  logic [ROW_WIDTH-1:0]  row_q, row_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    beat_d = beat_q;
    row_d  = row_q;
    if (clear_i) begin
      beat_d = '0;
    end else if (beat_en_i) begin
      row_d[beat_q*LAYER_1_BIT_WIDTH +: LAYER_1_BIT_WIDTH] = weight_i;
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q <= '0;
      row_q  <= '0;
    end else begin
      beat_q <= beat_d;
      row_q  <= row_d;
    end
  end

  assign row_o          = row_q;
  assign row_complete_o = beat_en_i && (beat_q == LAST_BEAT);

endmodule

// File: rtl/layer1_weight_sequencer.sv
// Layer 1 weight storage controller: serial load with timed latch writes, and
// handshaked row scan. Optional macro WEIGHT_CHECKSUM_EN adds weightChecksum.
module layer1_weight_sequencer
  import NNGlobals::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         loadStart,
  input  logic [LAYER_1_BIT_WIDTH-1:0] weightIn,
  input  logic                         weightValid,
  output logic                         weightReady,
  input  logic                         scanStart,
  input  logic                         scanReady,
  output logic                         storeWriteEnable,
  output logic [NODE_SEL_WIDTH-1:0]    storeNodeSelect,
  output logic [ROW_WIDTH-1:0]         storeWriteIn,
  output logic                         rowValid,
  output logic [NODE_SEL_WIDTH-1:0]    rowIndex,
  output logic                         rowLast,
  output logic                         busy,
  output logic                         loaded
`ifdef WEIGHT_CHECKSUM_EN
  ,
  output logic [15:0]                  weightChecksum
`endif
);

  seq_state_t                state_q, state_d;
  logic [NODE_SEL_WIDTH-1:0] row_q, row_d;
  logic                      loaded_q, loaded_d;
  logic                      fill_clear;
  logic                      beat_en;
  logic                      row_complete;

  assign weightReady = (state_q == ST_FILL);
  assign beat_en     = weightValid && weightReady;

  weight_row_assembler u_assembler (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear_i        (fill_clear),
    .beat_en_i      (beat_en),
    .weight_i       (weightIn),
    .row_o          (storeWriteIn),
    .row_complete_o (row_complete)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    loaded_d   = loaded_q;
    fill_clear = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (loadStart) begin
          state_d    = ST_FILL;
          loaded_d   = 1'b0;
          row_d      = '0;
          fill_clear = 1'b1;
        end else if (scanStart && loaded_q) begin
          state_d = ST_SCAN;
          row_d   = '0;
        end
      end
      ST_FILL: begin
        if (row_complete) state_d = ST_WR_SETUP;
      end
      ST_WR_SETUP: state_d = ST_WR_PULSE;
      ST_WR_PULSE: state_d = ST_WR_HOLD;
      ST_WR_HOLD: begin
        if (row_q == LAST_ROW) begin
          state_d  = ST_IDLE;
          loaded_d = 1'b1;
        end else begin
          state_d = ST_FILL;
          row_d   = row_q + NODE_SEL_WIDTH'(1);
        end
      end
      ST_SCAN: begin
        // The read path is combinational, so advancing here presents the next row next cycle.
        if (scanReady) begin
          if (row_q == LAST_ROW) state_d = ST_IDLE;
          else                   row_d   = row_q + NODE_SEL_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      loaded_q <= loaded_d;
    end
  end

  // Decoded straight from the state register: the latch enable is glitch-free and one cycle wide.
  assign storeWriteEnable = (state_q == ST_WR_PULSE);
  assign storeNodeSelect  = (state_q == ST_IDLE) ? '0 : row_q;
  assign rowValid         = (state_q == ST_SCAN);
  assign rowIndex         = storeNodeSelect;
  assign rowLast          = rowValid && (row_q == LAST_ROW);
  assign busy             = (state_q != ST_IDLE);
  assign loaded           = loaded_q;

`ifdef WEIGHT_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (fill_clear)                csum_d = '0;
    else if (beat_en && !loaded_q) csum_d = csum_q + 16'(weightIn);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign weightChecksum = csum_q;
`endif

endmodule
